fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//   Dual-width instruction fetch buffer between the fetch unit and the dual-issue decode stage
//   of superscalar_machine. Accepts 0-2 {pc, instr} pairs per cycle and presents the oldest
//   0-2 entries to decode in program order. Decode consumes 0-2 entries per cycle.
//   A flush on branch mispredict or redirect empties the queue in one cycle.
// PARAMETERS
//   DEPTH   8   entry count; power of two, >= 4
//   PC_W    32  program-counter width
//   INSN_W  32  instruction-word width
// PORTS
//   clk         in   1               rising-edge clock
//   rst         in   1               asynchronous, active-high reset
//   flush       in   1               discard all entries at next edge
//   in_valid    in   2               enqueue mask; legal values 00, 01, 11
//   in_pc0      in   PC_W            PC of older incoming instruction
//   in_instr0   in   INSN_W          older incoming instruction word
//   in_pc1      in   PC_W            PC of younger incoming instruction
//   in_instr1   in   INSN_W          younger incoming instruction word
//   in_ready    out  1               queue can take 2 entries this cycle
//   out_valid   out  2               bit0: >=1 entry held; bit1: >=2 entries held
//   out_pc0     out  PC_W            PC at head
//   out_instr0  out  INSN_W          instruction at head
//   out_pc1     out  PC_W            PC at head+1
//   out_instr1  out  INSN_W          instruction at head+1
//   out_accept  in   2               dequeue mask from decode; legal values 00, 01, 11
//   count       out  $clog2(DEPTH)+1 number of entries held
// BEHAVIOUR
//   - Storage: circular arrays of DEPTH entries. Head and tail pointers are log2(DEPTH) bits
//     and wrap modulo DEPTH. count is a separate register.
//   - in_ready = (count <= DEPTH-2). It is combinational from registered count only and never
//     depends on same-cycle out_accept.
//   - n_enq = in_ready ? {00:0, 01:1, 11:2} : 0.
//     Illegal in_valid 10 is treated as 00.
//     Entry 0 is written at tail, entry 1 at tail+1; tail += n_enq.
//   - out_valid[0] = (count >= 1) and out_valid[1] = (count >= 2).
//     The out_* data ports read mem[head] and mem[head+1] combinationally.
//     Data on a slot whose valid bit is 0 is don't-care.
//   - n_deq = out_accept masked by out_valid: 11 with count=1 dequeues 1; 10 dequeues 0.
//     head += n_deq.
//   - No bypass: an entry enqueued at edge N is first visible on out_* after edge N.
//     Latency is 1 cycle, even when the queue is empty.
//   - Simultaneous enqueue and dequeue: count_next = count + n_enq - n_deq.
//     Full throughput is 2 in / 2 out per cycle while DEPTH-2 >= count.
//   - Full boundary: at count = DEPTH-1 or DEPTH, in_ready = 0. At that point no enqueue
//     occurs, even of a single entry.
//   - Empty boundary: at count = 0, out_valid = 00, and any out_accept is ignored.
//   - Flush has priority: at the next edge head = tail = count = 0.
//     Enqueue and dequeue requests in the flush cycle are discarded.
//     Fetch presents redirected-path instructions from the following cycle.
//   - Reset (asynchronous, any time including mid-stream): head = tail = count = 0 immediately.
//     Thus out_valid = 00 and in_ready = 1 while rst is high and after it.
//     Array contents are not reset.
//   - Program order: out slot 0 is always older than slot 1.
//     Dequeue order equals enqueue order across wrap.
// TESTING
//   1. Reset: rst=1 mid-run with count=5 -> count=0, out_valid=00, in_ready=1 before next clk edge.
//   2. Enqueue {0x400000,0x24080001},{0x400004,0x24090002}, in_valid=11, out_accept=00
//      -> next cycle out_valid=11 with those pairs in order, count=2.
//   3. Fill with DEPTH=8: push 11 x3 then 01 -> count=7, in_ready=0; a further 11 push is
//      dropped and count stays 7; accept 01 -> count=6, in_ready=1.
//   4. Wrap and stream: 20 cycles of in_valid=11 plus out_accept=11 with sequential PCs
//      -> every dequeued PC = previous + 4, no gaps, count is constant.
//   5. Partial and illegal masks: count=1 with out_accept=11 -> count=0.
//      in_valid=10 -> no enqueue. out_accept=10 -> no dequeue.
//   6. Flush at count=6 with in_valid=11 and out_accept=11 in the same cycle
//      -> count=0 next cycle; a new 01 push is the next head.

Source files
------------

// File: rtl/fetch_queue.sv
// Dual-width in-order fetch queue: up to two {pc, instr} pairs enter and up to two
// leave per cycle, with a one-cycle flush and no enqueue-to-output bypass.
module fetch_queue #(
   parameter int DEPTH  = 8,
   parameter int PC_W   = 32,
   parameter int INSN_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [1:0]               in_valid,
   input  logic [PC_W-1:0]          in_pc0,
   input  logic [INSN_W-1:0]        in_instr0,
   input  logic [PC_W-1:0]          in_pc1,
   input  logic [INSN_W-1:0]        in_instr1,
   output logic                     in_ready,
   output logic [1:0]               out_valid,
   output logic [PC_W-1:0]          out_pc0,
   output logic [INSN_W-1:0]        out_instr0,
   output logic [PC_W-1:0]          out_pc1,
   output logic [INSN_W-1:0]        out_instr1,
   input  logic [1:0]               out_accept,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [PC_W-1:0]   r_pc_mem   [DEPTH];
   logic [INSN_W-1:0] r_insn_mem [DEPTH];
   logic [AW-1:0]     r_head;
   logic [AW-1:0]     r_tail;
   logic [CW-1:0]     r_count;

   logic [AW-1:0]     w_head1;
   logic [AW-1:0]     w_tail1;
   logic              w_ready;
   logic [1:0]        w_valid;
   logic [1:0]        w_n_enq;
   logic [1:0]        w_n_deq;

   assign w_head1 = r_head + AW'(1);
   assign w_tail1 = r_tail + AW'(1);

   // Ready looks only at the registered count, so space freed by a same-cycle dequeue is not reused.
   assign w_ready    = (r_count <= CW'(DEPTH - 2));
   assign w_valid[0] = (r_count >= CW'(1));
   assign w_valid[1] = (r_count >= CW'(2));

   always_comb begin
      w_n_enq = 2'd0;
      if (w_ready) begin
         case (in_valid)
            2'b01:   w_n_enq = 2'd1;
            2'b11:   w_n_enq = 2'd2;
            default: w_n_enq = 2'd0;
         endcase
      end
   end

   always_comb begin
      w_n_deq = 2'd0;
      case (out_accept)
         2'b01:   w_n_deq = w_valid[0] ? 2'd1 : 2'd0;
         2'b11:   w_n_deq = w_valid[1] ? 2'd2 : (w_valid[0] ? 2'd1 : 2'd0);
         default: w_n_deq = 2'd0;
      endcase
   end

   // Storage is deliberately left out of reset; valid tracking comes from r_count alone.
   always_ff @(posedge clk) begin
      if (!flush) begin
         if (w_n_enq != 2'd0) begin
            r_pc_mem[r_tail]   <= in_pc0;
            r_insn_mem[r_tail] <= in_instr0;
         end
         if (w_n_enq == 2'd2) begin
            r_pc_mem[w_tail1]   <= in_pc1;
            r_insn_mem[w_tail1] <= in_instr1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + AW'(w_n_deq);
         r_tail  <= r_tail + AW'(w_n_enq);
         r_count <= r_count + CW'(w_n_enq) - CW'(w_n_deq);
      end
   end

   assign in_ready   = w_ready;
   assign out_valid  = w_valid;
   assign out_pc0    = r_pc_mem[r_head];
   assign out_instr0 = r_insn_mem[r_head];
   assign out_pc1    = r_pc_mem[w_head1];
   assign out_instr1 = r_insn_mem[w_head1];
   assign count      = r_count;

endmodule
